// File: rtl/pacman_pkg.sv
// pacman_pkg: shared definitions for the Pac-Man sprite renderer.
//   dir_t        - facing direction encodings (matches the 2-bit dir port)
//   mouth_t      - mouth animation phases
//   RGB_*        - RGB444 colour constants
//   mouth_advance- next phase in the CLOSED->OPENING->OPEN->CLOSING cycle
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        MOUTH_CLOSED  = 2'd0,
        MOUTH_OPENING = 2'd1,
        MOUTH_OPEN    = 2'd2,
        MOUTH_CLOSING = 2'd3
    } mouth_t;

    localparam logic [11:0] RGB_YELLOW = 12'hFF0;
    localparam logic [11:0] RGB_BLACK  = 12'h000;

    function automatic mouth_t mouth_advance(input mouth_t m);
        mouth_t n;
        case (m)
            MOUTH_CLOSED:  n = MOUTH_OPENING;
            MOUTH_OPENING: n = MOUTH_OPEN;
            MOUTH_OPEN:    n = MOUTH_CLOSING;
            MOUTH_CLOSING: n = MOUTH_CLOSED;
            default:       n = MOUTH_CLOSED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pacman_mouth_fsm.sv
// pacman_mouth_fsm: frame counter plus four-phase mouth animation state.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   i_frame_tick   - p_tick & frame_start (one pulse per frame)
//   i_anim_en      - animation runs when high; low freezes counter and phase
//   o_mouth        - phase in effect for the current pixel; on a frame tick
//                    that advances the phase it already shows the new one
module pacman_mouth_fsm
    import pacman_pkg::*;
#(
    parameter int ANIM_DIV = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_frame_tick,
    input  logic   i_anim_en,
    output mouth_t o_mouth
);

    localparam int CNTW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ANIM_DIV - 1);

    logic [CNTW-1:0] r_cnt;
    mouth_t          r_state;
    logic            w_step;
    logic            w_wrap;

    assign w_step = i_frame_tick & i_anim_en;
    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= MOUTH_CLOSED;
        end else if (w_step) begin
            if (w_wrap) begin
                r_cnt   <= '0;
                r_state <= mouth_advance(r_state);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Look-ahead so the pixel carrying frame_start already uses the new phase.
    assign o_mouth = (w_step && w_wrap) ? mouth_advance(r_state) : r_state;

endmodule

// File: rtl/pacman_sprite.sv
// pacman_sprite: animated Pac-Man sprite (circle minus mouth wedge), two-stage
// registered pipeline advancing on p_tick.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   p_tick              - pixel enable
//   p_x, p_y            - current pixel coordinates
//   frame_start         - first-pixel-of-frame pulse (qualified by p_tick)
//   pos_x, pos_y, dir   - requested position / facing, latched per frame
//   anim_en             - mouth animation enable
//   blink               - (only with PACMAN_BLINK_EN) hide on alternate 8-frame periods
//   sprite_on, graph_rgb- pipelined pixel result, 2 p_ticks after the sample
// Optional build macro: PACMAN_BLINK_EN
module pacman_sprite
    import pacman_pkg::*;
#(
    parameter int          SIZE     = 16,
    parameter logic [11:0] COLOR    = RGB_YELLOW,
    parameter logic [11:0] BG_COLOR = RGB_BLACK,
    parameter int          ANIM_DIV = 4,
    parameter int          CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_tick,
    input  logic [CW-1:0] p_x,
    input  logic [CW-1:0] p_y,
    input  logic          frame_start,
    input  logic [CW-1:0] pos_x,
    input  logic [CW-1:0] pos_y,
    input  logic [1:0]    dir,
    input  logic          anim_en,
`ifdef PACMAN_BLINK_EN
    input  logic          blink,
`endif
    output logic          sprite_on,
    output logic [11:0]   graph_rgb
);

    localparam int LW  = $clog2(SIZE);
    localparam int DW  = LW + 2;
    localparam int SQW = 2 * DW;
    localparam logic signed [DW-1:0] SPAN   = DW'(SIZE - 1);
    localparam logic [SQW-1:0]       RAD2X4 = SQW'(SIZE * SIZE);

    // ---------------- per-frame latch ----------------
    logic          w_frame_tick;
    logic [CW-1:0] r_lx, r_ly;
    dir_t          r_dir;
    logic [CW-1:0] w_lx, w_ly;
    dir_t          w_dir;

    assign w_frame_tick = p_tick & frame_start;
    // The frame_start pixel itself already uses the newly requested values.
    assign w_lx  = w_frame_tick ? pos_x : r_lx;
    assign w_ly  = w_frame_tick ? pos_y : r_ly;
    assign w_dir = w_frame_tick ? dir_t'(dir) : r_dir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lx  <= '0;
            r_ly  <= '0;
            r_dir <= DIR_RIGHT;
        end else if (w_frame_tick) begin
            r_lx  <= pos_x;
            r_ly  <= pos_y;
            r_dir <= dir_t'(dir);
        end
    end

    mouth_t w_mouth;

    pacman_mouth_fsm #(
        .ANIM_DIV (ANIM_DIV)
    ) u_mouth (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (w_frame_tick),
        .i_anim_en    (anim_en),
        .o_mouth      (w_mouth)
    );

    logic w_hide;
`ifdef PACMAN_BLINK_EN
    logic [3:0] r_bcnt;
    logic [3:0] w_bcnt_inc;
    assign w_bcnt_inc = r_bcnt + 4'd1;
    assign w_hide     = blink & (w_frame_tick ? w_bcnt_inc[3] : r_bcnt[3]);
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_bcnt <= '0;
        else if (w_frame_tick)
            r_bcnt <= w_bcnt_inc;
    end
`else
    assign w_hide = 1'b0;
`endif

    // ---------------- stage 1: box test and doubled offsets ----------------
    logic [CW:0]           w_xe, w_ye, w_lxe, w_lye;
    logic                  w_in_box;
    logic [LW-1:0]         w_ox, w_oy;
    logic signed [DW-1:0]  w_du, w_dv;

    // One extra bit keeps lx+SIZE from wrapping near the coordinate limit.
    assign w_xe     = {1'b0, p_x};
    assign w_ye     = {1'b0, p_y};
    assign w_lxe    = {1'b0, w_lx};
    assign w_lye    = {1'b0, w_ly};
    assign w_in_box = (w_xe >= w_lxe) && (w_xe < w_lxe + (CW+1)'(SIZE)) &&
                      (w_ye >= w_lye) && (w_ye < w_lye + (CW+1)'(SIZE));

    // Only the in-box range 0..SIZE-1 matters, so LW bits of the offset suffice.
    assign w_ox = LW'(p_x - w_lx);
    assign w_oy = LW'(p_y - w_ly);
    assign w_du = $signed({1'b0, w_ox, 1'b0}) - SPAN;
    assign w_dv = $signed({1'b0, w_oy, 1'b0}) - SPAN;

    logic                 r_in_box_s1;
    logic signed [DW-1:0] r_du_s1, r_dv_s1;
    dir_t                 r_dir_s1;
    mouth_t               r_mouth_s1;
    logic                 r_hide_s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_box_s1 <= 1'b0;
            r_du_s1     <= '0;
            r_dv_s1     <= '0;
            r_dir_s1    <= DIR_RIGHT;
            r_mouth_s1  <= MOUTH_CLOSED;
            r_hide_s1   <= 1'b0;
        end else if (p_tick) begin
            r_in_box_s1 <= w_in_box;
            r_du_s1     <= w_du;
            r_dv_s1     <= w_dv;
            r_dir_s1    <= w_dir;
            r_mouth_s1  <= w_mouth;
            r_hide_s1   <= w_hide;
        end
    end

    // ---------------- stage 2: rotate, disc, wedge ----------------
    logic signed [DW-1:0]  w_a, w_b;
    always_comb begin
        w_a = r_du_s1;
        w_b = r_dv_s1;
        case (r_dir_s1)
            DIR_RIGHT: begin w_a =  r_du_s1; w_b = r_dv_s1; end
            DIR_LEFT:  begin w_a = -r_du_s1; w_b = r_dv_s1; end
            DIR_UP:    begin w_a = -r_dv_s1; w_b = r_du_s1; end
            DIR_DOWN:  begin w_a =  r_dv_s1; w_b = r_du_s1; end
            default:   ;
        endcase
    end

    logic signed [SQW-1:0] w_ax, w_bx;
    logic [SQW-1:0]        w_r2;
    logic                  w_disc;
    logic [DW-1:0]         w_babs;
    logic [DW:0]           w_au, w_b1, w_b2;
    logic                  w_apos, w_wedge, w_on_next;

    assign w_ax   = SQW'(w_a);
    assign w_bx   = SQW'(w_b);
    assign w_r2   = w_ax * w_ax + w_bx * w_bx;
    assign w_disc = (w_r2 <= RAD2X4);

    assign w_babs = w_b[DW-1] ? DW'(-w_b) : DW'(w_b);
    assign w_apos = !w_a[DW-1] && (w_a != '0);
    // With a > 0 established, the wedge bounds compare as plain magnitudes.
    assign w_au   = {1'b0, w_a};
    assign w_b1   = {1'b0, w_babs};
    assign w_b2   = {w_babs, 1'b0};

    always_comb begin
        w_wedge = 1'b0;
        case (r_mouth_s1)
            MOUTH_CLOSED:  w_wedge = 1'b0;
            MOUTH_OPENING,
            MOUTH_CLOSING: w_wedge = w_apos && (w_b2 <= w_au);
            MOUTH_OPEN:    w_wedge = w_apos && (w_b1 <= w_au);
            default:       w_wedge = 1'b0;
        endcase
    end

    assign w_on_next = r_in_box_s1 && w_disc && !w_wedge && !r_hide_s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sprite_on <= 1'b0;
            graph_rgb <= BG_COLOR;
        end else if (p_tick) begin
            sprite_on <= w_on_next;
            graph_rgb <= w_on_next ? COLOR : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_pacman_sprite.sv
// tb_pacman_sprite: randomized and directed checks of pacman_sprite against a
// geometric reference model (integer arithmetic on the sprite rules).
`timescale 1ns/1ps
module tb_pacman_sprite;

    localparam int          SIZE     = 16;
    localparam int          ANIM_DIV = 4;
    localparam int          CW       = 10;
    localparam logic [11:0] COLOR    = 12'hFF0;
    localparam logic [11:0] BG       = 12'h000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_tick = 1'b0;
    logic          frame_start = 1'b0;
    logic          anim_en = 1'b0;
    logic [CW-1:0] p_x = '0, p_y = '0, pos_x = '0, pos_y = '0;
    logic [1:0]    dir = '0;
    logic          sprite_on;
    logic [11:0]   graph_rgb;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_lx = 0, m_ly = 0, m_dir = 0, m_phase = 0, m_cnt = 0;
    bit m_prev = 1'b0, m_on = 1'b0;
    logic [11:0] exp_rgb;

    always #5 clk = ~clk;

    pacman_sprite #(
        .SIZE     (SIZE),
        .COLOR    (COLOR),
        .BG_COLOR (BG),
        .ANIM_DIV (ANIM_DIV),
        .CW       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_tick      (p_tick),
        .p_x         (p_x),
        .p_y         (p_y),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .dir         (dir),
        .anim_en     (anim_en),
`ifdef PACMAN_BLINK_EN
        .blink       (1'b0),
`endif
        .sprite_on   (sprite_on),
        .graph_rgb   (graph_rgb)
    );

    // phase: 0 closed, 1 opening, 2 open, 3 closing
    function automatic bit pix_on(input int px, input int py, input int lx,
                                  input int ly, input int d, input int phase);
        int du, dv, a, b, ab;
        if (px < lx || px >= lx + SIZE || py < ly || py >= ly + SIZE) return 1'b0;
        du = 2 * (px - lx) - (SIZE - 1);
        dv = 2 * (py - ly) - (SIZE - 1);
        case (d)
            0: begin a =  du; b = dv; end
            1: begin a = -du; b = dv; end
            2: begin a = -dv; b = du; end
            default: begin a = dv; b = du; end
        endcase
        ab = (b < 0) ? -b : b;
        if (a * a + b * b > SIZE * SIZE) return 1'b0;
        if ((phase == 1 || phase == 3) && a > 0 && 2 * ab <= a) return 1'b0;
        if (phase == 2 && a > 0 && ab <= a) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one clock with the given pixel inputs and advance the model.
    task automatic step(input int px, input int py, input bit fs, input bit pt);
        p_x = CW'(px);
        p_y = CW'(py);
        frame_start = fs;
        p_tick = pt;
        @(posedge clk);
        if (!rst_n) begin
            m_lx = 0; m_ly = 0; m_dir = 0; m_phase = 0; m_cnt = 0;
            m_prev = 1'b0; m_on = 1'b0;
        end else if (pt) begin
            if (fs) begin
                m_lx = int'(pos_x); m_ly = int'(pos_y); m_dir = int'(dir);
                if (anim_en) begin
                    if (m_cnt == ANIM_DIV - 1) begin
                        m_cnt = 0;
                        m_phase = (m_phase + 1) % 4;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            m_on   = m_prev;
            m_prev = pix_on(px, py, m_lx, m_ly, m_dir, m_phase);
        end
        exp_rgb = m_on ? COLOR : BG;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pos_x = 10'd300; pos_y = 10'd300; dir = 2'd1; anim_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(305, 305, 1'b1, 1'b1);
            n_checks++;
            if (sprite_on !== 1'b0 || graph_rgb !== 12'h000) begin
                n_fail++;
                $display("FAIL reset[%0d]: on=%b rgb=%h, required on=0 rgb=000", i, sprite_on, graph_rgb);
            end
        end
        rst_n = 1'b1;
        pos_x = 10'd100; pos_y = 10'd50; dir = 2'd0; anim_en = 1'b0;
        step(0, 0, 1'b1, 1'b1);
        step(108, 58, 1'b0, 1'b1);
        step(109, 58, 1'b0, 1'b1);
        n_checks++;
        if (sprite_on !== 1'b1 || graph_rgb !== 12'hFF0 || m_on !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pixel: on=%b rgb=%h model=%b, required on=1 rgb=ff0", sprite_on, graph_rgb, m_on);
        end
    endtask

    task automatic test_latch();
        int xs[4] = '{108, 208, 108, 208};
        bit fs_before[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bit req[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        pos_x = 10'd200;
        for (int i = 0; i < 4; i++) begin
            if (fs_before[i]) step(0, 0, 1'b1, 1'b1);
            step(xs[i], 58, 1'b0, 1'b1);
            step(0, 1, 1'b0, 1'b1);
            n_checks++;
            if (sprite_on !== req[i] || sprite_on !== m_on || graph_rgb !== exp_rgb) begin
                n_fail++;
                $display("FAIL latch[%0d]: on=%b rgb=%h, required on=%b rgb=%h", i, sprite_on, graph_rgb, req[i], exp_rgb);
            end
        end
        pos_x = 10'd100;
        step(0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_mouth();
        bit req;
        anim_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            step(0, 0, 1'b1, 1'b1);
            step(115, 57, 1'b0, 1'b1);
            step(0, 1, 1'b0, 1'b1);
            req = (((f + 1) / ANIM_DIV) % 4) == 0;
            n_checks++;
            if (sprite_on !== req || sprite_on !== m_on || graph_rgb !== exp_rgb) begin
                n_fail++;
                $display("FAIL mouth[%0d]: on=%b rgb=%h, required on=%b rgb=%h", f, sprite_on, graph_rgb, req, exp_rgb);
            end
        end
    endtask

    task automatic test_direction();
        int ys[4] = '{50, 65, 50, 65};
        bit req[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        dir = 2'd2;
        anim_en = 1'b1;
        for (int i = 0; i < 16 && m_phase != 2; i++) step(0, 0, 1'b1, 1'b1);
        anim_en = 1'b0;
        step(0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                dir = 2'd3;
                step(0, 0, 1'b1, 1'b1);
            end
            step(107, ys[i], 1'b0, 1'b1);
            step(0, 1, 1'b0, 1'b1);
            n_checks++;
            if (sprite_on !== req[i] || sprite_on !== m_on || graph_rgb !== exp_rgb) begin
                n_fail++;
                $display("FAIL direction[%0d]: on=%b rgb=%h, required on=%b rgb=%h", i, sprite_on, graph_rgb, req[i], exp_rgb);
            end
        end
        dir = 2'd0;
    endtask

    task automatic test_edge();
        pos_x = 10'd1020;
        step(0, 0, 1'b1, 1'b1);
        for (int x = 0; x < 16; x++) begin
            step((x < 12) ? x : 1008 + x, 58, 1'b0, 1'b1);
            step(0, 1, 1'b0, 1'b1);
            n_checks++;
            if (sprite_on !== m_on || graph_rgb !== exp_rgb || (x < 12 && sprite_on !== 1'b0)) begin
                n_fail++;
                $display("FAIL edge[%0d]: on=%b rgb=%h, required on=%b rgb=%h", x, sprite_on, graph_rgb, m_on, exp_rgb);
            end
        end
        pos_x = 10'd100;
        step(0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_tick_gating();
        logic        held_on;
        logic [11:0] held_rgb;
        step(108, 58, 1'b0, 1'b1);
        step(109, 58, 1'b0, 1'b1);
        held_on  = m_on;
        held_rgb = exp_rgb;
        for (int i = 0; i < 5; i++) begin
            step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (sprite_on !== held_on || graph_rgb !== held_rgb) begin
                n_fail++;
                $display("FAIL tick_gate[%0d]: on=%b rgb=%h, required on=%b rgb=%h", i, sprite_on, graph_rgb, held_on, held_rgb);
            end
        end
        step(0, 2, 1'b0, 1'b1);
        n_checks++;
        if (sprite_on !== m_on || graph_rgb !== exp_rgb) begin
            n_fail++;
            $display("FAIL tick_resume: on=%b rgb=%h, required on=%b rgb=%h", sprite_on, graph_rgb, m_on, exp_rgb);
        end
    endtask

    task automatic test_anim_freeze();
        int  rec_phase;
        bit  req;
        anim_en = 1'b1;
        for (int i = 0; i < 16 && (m_phase == 0 || m_cnt != 0); i++) step(0, 0, 1'b1, 1'b1);
        anim_en = 1'b0;
        rec_phase = m_phase;
        req = pix_on(115, 57, 100, 50, 0, rec_phase);
        for (int f = 0; f < 10; f++) begin
            step(0, 0, 1'b1, 1'b1);
            step(115, 57, 1'b0, 1'b1);
            step(0, 1, 1'b0, 1'b1);
            n_checks++;
            if (sprite_on !== req || graph_rgb !== (req ? COLOR : BG)) begin
                n_fail++;
                $display("FAIL anim_freeze[%0d]: on=%b rgb=%h, required on=%b", f, sprite_on, graph_rgb, req);
            end
        end
    endtask

    task automatic test_random();
        bit fs;
        for (int i = 0; i < 600; i++) begin
            fs = ($urandom_range(0, 29) == 0);
            if (fs) begin
                pos_x   = CW'($urandom_range(0, 1023));
                pos_y   = CW'($urandom_range(0, 1023));
                dir     = 2'($urandom_range(0, 3));
                anim_en = 1'($urandom_range(0, 3) != 0);
            end
            step((m_lx + $urandom_range(0, SIZE + 3) + 1022) % 1024,
                 (m_ly + $urandom_range(0, SIZE + 3) + 1022) % 1024,
                 fs, 1'($urandom_range(0, 3) != 0));
            n_checks++;
            if (sprite_on !== m_on || graph_rgb !== exp_rgb) begin
                n_fail++;
                $display("FAIL random[%0d]: on=%b rgb=%h, required on=%b rgb=%h", i, sprite_on, graph_rgb, m_on, exp_rgb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latch();
        test_mouth();
        test_direction();
        test_edge();
        test_tick_gating();
        test_anim_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pacman_sprite.md
Name: pacman_sprite

Overview:
- Parametrised, animated Pac-Man sprite renderer for the VGA pixel pipeline.
- Replaces the fixed 10x10 ROM sprite with an arithmetic circle-minus-wedge shape:
  - runtime position and facing direction;
  - four-phase mouth animation advanced on frame boundaries;
  - registered two-stage pixel pipeline.
- Sits between the VGA sync generator (p_x, p_y, p_tick, frame_start) and the playfield colour mux.

Parameters:
- SIZE, 16, sprite edge in pixels; even, 8..32; radius R = SIZE/2.
- COLOR, 12'hFF0, RGB444 sprite colour.
- BG_COLOR, 12'h000, RGB444 output when sprite is off.
- ANIM_DIV, 4, frames per mouth phase; >= 1.
- CW, 10, pixel coordinate width.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- p_tick, in, 1, pixel enable; all pipeline and animation state advances only when high.
- p_x, in, CW, current pixel column.
- p_y, in, CW, current pixel row.
- frame_start, in, 1, one-p_tick pulse at the first pixel of a frame.
- pos_x, in, CW, requested sprite left edge.
- pos_y, in, CW, requested sprite top edge.
- dir, in, 2, requested facing: 0 right, 1 left, 2 up, 3 down.
- anim_en, in, 1, mouth animation runs when high.
- sprite_on, out, 1, current pipelined pixel belongs to the sprite.
- graph_rgb, out, 12, pipelined pixel colour.

Behaviour:
- Reset (rst_n low at a clk edge; p_tick is ignored during reset):
  - sprite_on = 0, graph_rgb = BG_COLOR;
  - latched position = 0,0; latched dir = 0;
  - mouth state = CLOSED; frame counter = 0.
- Latching: pos_x, pos_y and dir are sampled only on a cycle where p_tick & frame_start are both high. No tearing within a frame; the new values apply from that same pixel (0,0) onward.
- Stage 1, on p_tick:
  - in_box = (lx <= p_x < lx+SIZE) && (ly <= p_y < ly+SIZE); use CW+1-bit compares so the right/bottom edge does not wrap near 2^CW.
  - Register signed offsets du = 2*(p_x-lx) - (SIZE-1) and dv = 2*(p_y-ly) - (SIZE-1). These are doubled, odd-valued offsets measured from the pixel-centre grid.
- Stage 2, on p_tick:
  - Rotate to a right-facing frame (a = forward axis, b = lateral axis):
    - right: a = du, b = dv;
    - left: a = -du, b = dv;
    - up: a = -dv, b = du;
    - down: a = dv, b = du.
  - disc = a*a + b*b <= SIZE*SIZE.
  - wedge depends on mouth state:
    - CLOSED: wedge = 0;
    - HALF: wedge = (a > 0) && (2*|b| <= a);
    - OPEN: wedge = (a > 0) && (|b| <= a).
  - sprite_on <= in_box && disc && !wedge.
  - graph_rgb <= sprite_on_next ? COLOR : BG_COLOR.
- Latency: exactly 2 p_tick pulses from a (p_x, p_y) sample to its output. With p_tick low, the outputs hold.
- Animation FSM: CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED.
  - OPENING and CLOSING render as HALF.
  - The frame counter increments on p_tick & frame_start & anim_en. On reaching ANIM_DIV-1 it wraps to 0 and the FSM advances.
  - anim_en low freezes both the state and the counter.
- Simultaneous frame_start and a phase advance: the new phase applies from that pixel, consistent with the position latch.
- Arithmetic: squares sized 2*(clog2(SIZE)+2) bits; no truncation.

Optional Feature:
- PACMAN_BLINK_EN:
  - When defined, adds input blink (1 bit). While blink is high, the sprite is suppressed (sprite_on = 0, BG_COLOR) on alternate 8-frame periods.
  - Uses a 4-bit free-running frame counter, reset to 0 and advanced on p_tick & frame_start; the sprite is hidden when bit 3 is 1.
  - When undefined, there is no blink port and no counter; behaviour is as above.

Decomposition:
- Shared package pacman_pkg:
  - direction encodings DIR_RIGHT/LEFT/UP/DOWN;
  - mouth state enum;
  - RGB444 colour constants.
- One natural sub-module: pacman_mouth_fsm, holding the frame counter and the four-state FSM and outputting the mouth phase.

Test Plan:
1. Reset: hold rst_n low 3 clk with p_tick high -> sprite_on=0, graph_rgb=12'h000; release, frame_start with pos=(100,50) -> pixel (108,58) on output 2 p_ticks later shows 12'hFF0.
2. Latch timing: change pos_x to 200 mid-frame -> rendering stays at 100 until the next frame_start, then moves to 200.
3. Mouth: dir=0, anim_en=1, ANIM_DIV=4 -> pixel (115,57) (a=15, b=-1, disc true) off in OPEN/HALF, on in CLOSED; phase sequence changes every 4 frames, period 16.
4. Direction: dir=2 in OPEN phase -> wedge pixels at top centre (p_y=ly) off, bottom centre on; dir=3 mirrors this.
5. Edge: pos_x=1020, SIZE=16 -> no sprite pixels at p_x 0..11 (no wrap).
6. p_tick gating: p_tick low 5 clk mid-line -> outputs frozen; anim_en=0 across 10 frames -> mouth phase unchanged.
